// File: rtl/dram_port_arbiter.sv
// Multi-port arbiter in front of a single synchronous DRAM port.
// Grants one requester per cycle (round-robin or fixed priority), supports
// lock-based ownership, and returns read data tagged back to the issuing port.
module dram_port_arbiter #(
    parameter int unsigned N_PORTS = 3,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned RR_MODE = 1
) (
    input  logic                        clk_in,
    input  logic                        clear_switch,
    input  logic [N_PORTS-1:0]          req,
    input  logic [N_PORTS-1:0]          lock,
    input  logic [N_PORTS-1:0]          we,
    input  logic [N_PORTS*ADDR_W-1:0]   addr,
    input  logic [N_PORTS*DATA_W-1:0]   wdata,
    output logic [N_PORTS-1:0]          gnt,
    output logic [N_PORTS-1:0]          rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_wren,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int unsigned PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StLocked
    } state_t;

    state_t              r_state;
    logic [PTR_W-1:0]    r_last;
    logic [PTR_W-1:0]    r_owner;
    logic [N_PORTS-1:0]  r_gnt;
    logic                r_wren;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [N_PORTS-1:0]  r_rd_pipe [RD_LAT];

    logic [ADDR_W-1:0]   w_addr_arr  [N_PORTS];
    logic [DATA_W-1:0]   w_wdata_arr [N_PORTS];
    logic [PTR_W-1:0]    w_cand;
    logic                w_arb_found;
    logic [PTR_W-1:0]    w_arb_idx;
    logic                w_lock_hold;
    logic                w_sel_valid;
    logic [PTR_W-1:0]    w_sel_idx;
    logic [N_PORTS-1:0]  w_sel_onehot;
    logic [N_PORTS-1:0]  w_rd_tag;

    // Port index (base + off) modulo N_PORTS.
    function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base,
                                                 input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        sum = sum % N_PORTS;
        return sum[PTR_W-1:0];
    endfunction

    // Unpack the concatenated per-port address and write-data buses.
    always_comb begin
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            w_addr_arr[i]  = addr[i*ADDR_W +: ADDR_W];
            w_wdata_arr[i] = wdata[i*DATA_W +: DATA_W];
        end
    end

    // Pick the winner: round-robin starts just after the last granted port.
    always_comb begin
        w_cand      = '0;
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            w_cand = (RR_MODE != 0) ? rot_idx(r_last, i + 1) : PTR_W'(i);
            if (!w_arb_found && req[w_cand]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = w_cand;
            end
        end
    end

    // While the owner keeps lock high, only the owner can be served; an idle
    // owner still keeps the port, so that cycle carries no access.
    always_comb begin
        w_lock_hold  = (r_state == StLocked) && lock[r_owner];
        w_sel_valid  = w_lock_hold ? req[r_owner] : w_arb_found;
        w_sel_idx    = w_lock_hold ? r_owner : w_arb_idx;
        w_sel_onehot = '0;
        w_sel_onehot[w_sel_idx] = w_sel_valid;
    end

    // Arbitration FSM with registered grant and DRAM command outputs.
    always_ff @(posedge clk_in) begin
        if (clear_switch) begin
            r_state     <= StIdle;
            r_last      <= PTR_W'(N_PORTS - 1);
            r_owner     <= '0;
            r_gnt       <= '0;
            r_wren      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_gnt  <= w_sel_onehot;
            r_wren <= w_sel_valid & we[w_sel_idx];
            if (w_sel_valid) begin
                r_mem_addr  <= w_addr_arr[w_sel_idx];
                r_mem_wdata <= w_wdata_arr[w_sel_idx];
                r_last      <= w_sel_idx;
            end
            if (w_lock_hold) begin
                r_state <= StLocked;
            end else if (w_arb_found && lock[w_arb_idx]) begin
                r_state <= StLocked;
                r_owner <= w_arb_idx;
            end else if (w_arb_found) begin
                r_state <= StAccess;
            end else begin
                r_state <= StIdle;
            end
        end
    end

    // A read is a grant cycle without write enable.
    assign w_rd_tag = r_gnt & ~{N_PORTS{r_wren}};

    // Read-tag shift pipeline: stage RD_LAT-1 lines up with DRAM q.
    always_ff @(posedge clk_in) begin
        if (clear_switch) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_rd_pipe[k] <= '0;
            end
        end else begin
            r_rd_pipe[0] <= w_rd_tag;
            for (int k = 1; k < RD_LAT; k++) begin
                r_rd_pipe[k] <= r_rd_pipe[k-1];
            end
        end
    end

    assign gnt       = r_gnt;
    assign rvalid    = r_rd_pipe[RD_LAT-1];
    assign rdata     = (|r_rd_pipe[RD_LAT-1]) ? mem_rdata : '0;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wren  = r_wren;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench: three arbiters share stimulus -- A (round-robin, latency 1),
// B (round-robin, latency 2), C (fixed priority, latency 1).
module tb_dram_port_arbiter;

    logic        clk = 1'b0;
    logic        clear;
    logic [2:0]  req, lock, we;
    logic [47:0] addr;
    logic [23:0] wdata;

    logic [2:0]  gnt_a, rvalid_a, gnt_b, rvalid_b, gnt_c, rvalid_c;
    logic [7:0]  rdata_a, rdata_b, rdata_c;
    logic [15:0] maddr_a, maddr_b, maddr_c;
    logic [7:0]  mwd_a, mwd_b, mwd_c;
    logic        mwren_a, mwren_b, mwren_c;
    logic [7:0]  q_a, q_b1, q_b2;
    logic [7:0]  mem_a [256];
    logic [7:0]  mem_b [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dram_port_arbiter #(.N_PORTS(3), .ADDR_W(16), .DATA_W(8), .RD_LAT(1), .RR_MODE(1)) u_dut_a (
        .clk_in(clk), .clear_switch(clear), .req(req), .lock(lock), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a), .mem_addr(maddr_a),
        .mem_wdata(mwd_a), .mem_wren(mwren_a), .mem_rdata(q_a)
    );

    dram_port_arbiter #(.N_PORTS(3), .ADDR_W(16), .DATA_W(8), .RD_LAT(2), .RR_MODE(1)) u_dut_b (
        .clk_in(clk), .clear_switch(clear), .req(req), .lock(lock), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b), .mem_addr(maddr_b),
        .mem_wdata(mwd_b), .mem_wren(mwren_b), .mem_rdata(q_b2)
    );

    dram_port_arbiter #(.N_PORTS(3), .ADDR_W(16), .DATA_W(8), .RD_LAT(1), .RR_MODE(0)) u_dut_c (
        .clk_in(clk), .clear_switch(clear), .req(req), .lock(lock), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt_c), .rvalid(rvalid_c), .rdata(rdata_c), .mem_addr(maddr_c),
        .mem_wdata(mwd_c), .mem_wren(mwren_c), .mem_rdata(8'h00)
    );

    // Synchronous DRAM models: one and two cycles of read latency.
    always_ff @(posedge clk) begin
        if (mwren_a) mem_a[maddr_a[7:0]] <= mwd_a;
        q_a <= mem_a[maddr_a[7:0]];
        if (mwren_b) mem_b[maddr_b[7:0]] <= mwd_b;
        q_b1 <= mem_b[maddr_b[7:0]];
        q_b2 <= q_b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] rr_exp [6];
    logic [2:0] fx_exp [4];

    initial begin
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        fx_exp = '{3'b010, 3'b100, 3'b010, 3'b100};
        clear = 1'b1; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        tick(); tick();
        chk("rst_gnt", gnt_a, 3'b000);
        chk("rst_rvalid", rvalid_a, 3'b000);
        chk("rst_wren", mwren_a, 1'b0);
        chk("rst_rdata", rdata_a, 8'h00);
        chk("rst_maddr", maddr_a, 16'h0000);
        chk("rst_mwdata", mwd_a, 8'h00);
        chk("rst_rvalid_b", rvalid_b, 3'b000);
        clear = 1'b0;

        // Port 0 locks and writes 0x3C to 0x40 while port 2 waits to read 0x40.
        req = 3'b101; lock = 3'b001; we = 3'b001;
        addr[15:0] = 16'h0040; addr[47:32] = 16'h0040; wdata[7:0] = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) lock = 3'b101;
            tick();
            chk("lock_gnt", gnt_a, 3'b001);
            chk("lock_wren", mwren_a, 1'b1);
        end
        req = 3'b100; lock = 3'b001;
        tick();
        chk("lock_idle_gnt", gnt_a, 3'b000);
        chk("lock_idle_wren", mwren_a, 1'b0);
        chk("lock_idle_maddr", maddr_a, 16'h0040);
        lock = 3'b000;
        tick();
        chk("unlock_gnt", gnt_a, 3'b100);
        chk("unlock_wren", mwren_a, 1'b0);
        req = 3'b000;
        tick();
        chk("unlock_gnt_idle", gnt_a, 3'b000);
        chk("unlock_rvalid_a", rvalid_a, 3'b100);
        chk("unlock_rdata_a", rdata_a, 8'h3C);
        chk("unlock_rvalid_b0", rvalid_b, 3'b000);
        tick();
        chk("unlock_rvalid_b", rvalid_b, 3'b100);
        chk("unlock_rdata_b", rdata_b, 8'h3C);

        // All three request continuously.
        req = 3'b111; we = 3'b000; lock = 3'b000;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_gnt", gnt_a, rr_exp[i]);
            chk("fixed_all_gnt", gnt_c, 3'b001);
            if (i > 0) chk("rr_rvalid", rvalid_a, rr_exp[i-1]);
        end
        req = 3'b000;
        tick();
        chk("rr_end_gnt", gnt_a, 3'b000);
        chk("rr_end_rvalid", rvalid_a, 3'b100);

        // Ports 1 and 2 request continuously.
        req = 3'b110;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fixed_gnt", gnt_c, 3'b010);
            chk("rr110_gnt", gnt_a, fx_exp[i]);
        end
        req = 3'b000;
        tick();

        // Port 1 writes 0xA5 to 0x0012, then port 0 reads it back.
        req = 3'b010; we = 3'b010; addr[31:16] = 16'h0012; wdata[15:8] = 8'hA5;
        tick();
        chk("wr_gnt", gnt_a, 3'b010);
        chk("wr_wren", mwren_a, 1'b1);
        chk("wr_maddr", maddr_a, 16'h0012);
        chk("wr_mwdata", mwd_a, 8'hA5);
        req = 3'b001; we = 3'b000; addr[15:0] = 16'h0012;
        tick();
        chk("rd_gnt_a", gnt_a, 3'b001);
        chk("rd_gnt_b", gnt_b, 3'b001);
        chk("rd_wren", mwren_a, 1'b0);
        chk("rd_maddr", maddr_a, 16'h0012);
        req = 3'b000;
        tick();
        chk("rd_rvalid_a", rvalid_a, 3'b001);
        chk("rd_rdata_a", rdata_a, 8'hA5);
        chk("rd_rvalid_b_early", rvalid_b, 3'b000);
        tick();
        chk("rd_rvalid_b", rvalid_b, 3'b001);
        chk("rd_rdata_b", rdata_b, 8'hA5);
        chk("rd_rvalid_a_done", rvalid_a, 3'b000);
        chk("rd_hold_maddr", maddr_a, 16'h0012);
        chk("rd_hold_wren", mwren_a, 1'b0);

        // Port 2 read, then reset while its tag is in flight on B.
        req = 3'b100;
        tick();
        chk("flush_gnt_b", gnt_b, 3'b100);
        req = 3'b000;
        tick();
        chk("flush_rvalid_a", rvalid_a, 3'b100);
        chk("flush_rdata_a", rdata_a, 8'h3C);
        chk("flush_pending_b", rvalid_b, 3'b000);
        clear = 1'b1; req = 3'b011;
        tick();
        chk("flush_gnt", gnt_b, 3'b000);
        chk("flush_rvalid_b", rvalid_b, 3'b000);
        chk("flush_rdata_b", rdata_b, 8'h00);
        chk("flush_wren", mwren_b, 1'b0);
        chk("flush_maddr", maddr_b, 16'h0000);
        chk("flush_mwdata", mwd_b, 8'h00);
        clear = 1'b0;
        tick();
        chk("post_rst_gnt", gnt_b, 3'b001);
        chk("post_rst_rvalid", rvalid_b, 3'b000);
        req = 3'b000;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
